// File: rtl/gemm_seq_ctrl_pkg.sv
// gemm_seq_ctrl_pkg: shared widths, capacity limits, FSM states and chunk-count helper
package gemm_seq_ctrl_pkg;
    localparam int DIM_WIDTH       = 32;
    localparam int VECTOR_LENGTH   = 16;
    localparam int IMEM_ADDR_WIDTH = 6;
    localparam int WMEM_ADDR_WIDTH = 6;
    localparam int OMEM_ADDR_WIDTH = 10;
    localparam int VEC_CAP         = 64;
    localparam int OUT_CAP         = 1024;
    localparam int CNT_W           = 7;
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_DRAIN, S_DONE} state_t;
    function automatic logic [63:0] calc_kt(input logic [DIM_WIDTH-1:0] m);
        return ({32'd0, m} + 64'd15) >> 4;
    endfunction
endpackage

// File: rtl/gemm_seq_ctrl_if.sv
// gemm_seq_ctrl_if: control, buffer-read, SIMD and OMEM-write signals; master is the sequencer
interface gemm_seq_ctrl_if;
    import gemm_seq_ctrl_pkg::*;
    logic                       start;
    logic [DIM_WIDTH-1:0]       dim_l, dim_m, dim_n;
    logic                       busy, done, err;
    logic                       imem_re;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic                       wmem_re;
    logic [WMEM_ADDR_WIDTH-1:0] wmem_addr;
    logic                       vec_valid, vec_first, vec_last;
    logic [VECTOR_LENGTH-1:0]   vec_mask;
    logic                       psum_valid;
    logic                       omem_we;
    logic [OMEM_ADDR_WIDTH-1:0] omem_addr;
    modport master (
        input  start, dim_l, dim_m, dim_n, psum_valid,
        output busy, done, err, imem_re, imem_addr, wmem_re, wmem_addr,
               vec_valid, vec_first, vec_last, vec_mask, omem_we, omem_addr
    );
    modport slave (
        output start, dim_l, dim_m, dim_n, psum_valid,
        input  busy, done, err, imem_re, imem_addr, wmem_re, wmem_addr,
               vec_valid, vec_first, vec_last, vec_mask, omem_we, omem_addr
    );
endinterface

// File: rtl/gemm_seq_addr_gen.sv
// gemm_seq_addr_gen: l/n/k loop counters with running A-row and B-column bases (adders only)
module gemm_seq_addr_gen
    import gemm_seq_ctrl_pkg::*;
(
    input  logic                       ap_clk,
    input  logic                       areset,
    input  logic                       i_init,
    input  logic                       i_step,
    input  logic [CNT_W-1:0]           i_kt,
    input  logic [CNT_W-1:0]           i_l,
    input  logic [CNT_W-1:0]           i_n,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [WMEM_ADDR_WIDTH-1:0] o_wmem_addr,
    output logic                       o_k_first,
    output logic                       o_k_last,
    output logic                       o_all_last
);
    logic [CNT_W-1:0] r_k, r_n, r_l, r_ibase, r_wbase;
    logic [CNT_W-1:0] w_iaddr, w_waddr;
    logic             w_n_last, w_l_last;
    assign w_iaddr     = r_ibase + r_k;
    assign w_waddr     = r_wbase + r_k;
    assign o_imem_addr = w_iaddr[IMEM_ADDR_WIDTH-1:0];
    assign o_wmem_addr = w_waddr[WMEM_ADDR_WIDTH-1:0];
    assign o_k_first   = r_k == '0;
    assign o_k_last    = r_k == i_kt - 7'd1;
    assign w_n_last    = r_n == i_n - 7'd1;
    assign w_l_last    = r_l == i_l - 7'd1;
    assign o_all_last  = o_k_last && w_n_last && w_l_last;
    // Advance k innermost, then n (B base steps by KT), then l (A base steps by KT)
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset || i_init) begin
            r_k     <= '0;
            r_n     <= '0;
            r_l     <= '0;
            r_ibase <= '0;
            r_wbase <= '0;
        end else if (i_step) begin
            if (!o_k_last) begin
                r_k <= r_k + 7'd1;
            end else begin
                r_k <= '0;
                if (!w_n_last) begin
                    r_n     <= r_n + 7'd1;
                    r_wbase <= r_wbase + i_kt;
                end else begin
                    r_n     <= '0;
                    r_wbase <= '0;
                    r_l     <= r_l + 7'd1;
                    r_ibase <= r_ibase + i_kt;
                end
            end
        end
    end
endmodule

// File: rtl/gemm_seq_ctrl.sv
// gemm_seq_ctrl: GEMM sequencer issuing A/B vector reads and OMEM write addresses.
// Optional busy-cycle counter port perf_cycles enabled by GEMM_SEQ_CTRL_PERF_CNT_EN.
module gemm_seq_ctrl
    import gemm_seq_ctrl_pkg::*;
(
    input  logic ap_clk,
    input  logic areset,
    gemm_seq_ctrl_if.master ctrl
`ifdef GEMM_SEQ_CTRL_PERF_CNT_EN
    , output logic [31:0] perf_cycles
`endif
);
    state_t                 r_state, w_next;
    logic [DIM_WIDTH-1:0]   r_l, r_m, r_n;
    logic                   r_err;
    logic [CNT_W-1:0]       r_kt;
    logic [OMEM_ADDR_WIDTH:0] r_total, r_wcnt;
    logic                   r_vec_valid, r_vec_first, r_vec_last;
    logic [VECTOR_LENGTH-1:0] r_vec_mask;
    logic [63:0]            w_kt, w_lkt, w_nkt, w_ln;
    logic                   w_bad, w_issue, w_accept, w_start, w_busy;
    logic                   w_k_first, w_k_last, w_all_last;
    assign w_kt     = calc_kt(r_m);
    assign w_lkt    = {32'd0, r_l} * w_kt;
    assign w_nkt    = {32'd0, r_n} * w_kt;
    assign w_ln     = {32'd0, r_l} * {32'd0, r_n};
    assign w_bad    = r_l == '0 || r_m == '0 || r_n == '0 ||
                      w_lkt > 64'(VEC_CAP) || w_nkt > 64'(VEC_CAP) || w_ln > 64'(OUT_CAP);
    assign w_start  = r_state == S_IDLE && ctrl.start;
    assign w_issue  = r_state == S_RUN;
    assign w_busy   = r_state == S_CHECK || r_state == S_RUN || r_state == S_DRAIN;
    assign w_accept = ctrl.psum_valid && (r_state == S_RUN || r_state == S_DRAIN);
    assign ctrl.busy      = w_busy;
    assign ctrl.done      = r_state == S_DONE;
    assign ctrl.err       = r_err;
    assign ctrl.imem_re   = w_issue;
    assign ctrl.wmem_re   = w_issue;
    assign ctrl.vec_valid = r_vec_valid;
    assign ctrl.vec_first = r_vec_first;
    assign ctrl.vec_last  = r_vec_last;
    assign ctrl.vec_mask  = r_vec_mask;
    assign ctrl.omem_we   = w_accept;
    assign ctrl.omem_addr = r_wcnt[OMEM_ADDR_WIDTH-1:0];
    gemm_seq_addr_gen u_addr (
        .ap_clk      (ap_clk),
        .areset      (areset),
        .i_init      (r_state == S_CHECK),
        .i_step      (w_issue),
        .i_kt        (r_kt),
        .i_l         (r_l[CNT_W-1:0]),
        .i_n         (r_n[CNT_W-1:0]),
        .o_imem_addr (ctrl.imem_addr),
        .o_wmem_addr (ctrl.wmem_addr),
        .o_k_first   (w_k_first),
        .o_k_last    (w_k_last),
        .o_all_last  (w_all_last)
    );
    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = ctrl.start ? S_CHECK : S_IDLE;
            S_CHECK: w_next = w_bad ? S_DONE : S_RUN;
            S_RUN:   w_next = w_all_last ? S_DRAIN : S_RUN;
            S_DRAIN: w_next = r_wcnt == r_total ? S_DONE : S_DRAIN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    // State register
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    // Latch dims on start; derive KT, output count and error flag in CHECK
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            r_l     <= '0;
            r_m     <= '0;
            r_n     <= '0;
            r_err   <= 1'b0;
            r_kt    <= '0;
            r_total <= '0;
        end else if (w_start) begin
            r_l   <= ctrl.dim_l;
            r_m   <= ctrl.dim_m;
            r_n   <= ctrl.dim_n;
            r_err <= 1'b0;
        end else if (r_state == S_CHECK) begin
            r_err   <= w_bad;
            r_kt    <= w_kt[CNT_W-1:0];
            r_total <= w_ln[OMEM_ADDR_WIDTH:0];
        end
    end
    // OMEM write counter, one step per accepted partial sum
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset)                     r_wcnt <= '0;
        else if (r_state == S_CHECK)    r_wcnt <= '0;
        else if (w_accept)              r_wcnt <= r_wcnt + 11'd1;
    end
    // Vector sideband delayed one cycle to line up with RAM read data
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            r_vec_valid <= 1'b0;
            r_vec_first <= 1'b0;
            r_vec_last  <= 1'b0;
            r_vec_mask  <= '0;
        end else begin
            r_vec_valid <= w_issue;
            r_vec_first <= w_issue && w_k_first;
            r_vec_last  <= w_issue && w_k_last;
            r_vec_mask  <= !w_issue ? '0 :
                           (w_k_last && r_m[3:0] != 4'd0) ? (16'd1 << r_m[3:0]) - 16'd1 : '1;
        end
    end
`ifdef GEMM_SEQ_CTRL_PERF_CNT_EN
    logic [31:0] r_perf;
    assign perf_cycles = r_perf;
    // Saturating busy-cycle counter, cleared on an accepted start
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset)                     r_perf <= '0;
        else if (w_start)               r_perf <= '0;
        else if (w_busy && r_perf != '1) r_perf <= r_perf + 32'd1;
    end
`endif
endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// tb_gemm_seq_ctrl: randomized self-checking bench against a loop-nest reference model
module tb_gemm_seq_ctrl;
    import gemm_seq_ctrl_pkg::*;
    logic ap_clk = 1'b0;
    logic areset = 1'b1;
    int   n_chk  = 0;
    int   n_err  = 0;
    always #5 ap_clk = ~ap_clk;
    gemm_seq_ctrl_if bus ();
`ifdef GEMM_SEQ_CTRL_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif
    gemm_seq_ctrl dut (
        .ap_clk (ap_clk),
        .areset (areset),
        .ctrl   (bus.master)
`ifdef GEMM_SEQ_CTRL_PERF_CNT_EN
        , .perf_cycles (perf_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic run(input int L, input int M, input int N, input int lat, input int poke);
        int kt    = (M + 15) / 16;
        int T     = L * N * kt;
        int nw    = 0;
        int w_last = -1;
        int done_f = -1;
        int due[$];
        @(negedge ap_clk);
        bus.dim_l = L;
        bus.dim_m = M;
        bus.dim_n = N;
        bus.start = 1'b1;
        for (int f = 0; f < 4000 && done_f < 0; f++) begin
            @(negedge ap_clk);
            bus.start = (f == poke);
            if (f == poke) begin
                bus.dim_l = 3;
                bus.dim_m = 5;
                bus.dim_n = 7;
            end
            if (f == 0) check("err_cleared", bus.err, 0);
            check("imem_re", bus.imem_re, f >= 1 && f <= T);
            check("vec_valid", bus.vec_valid, f >= 2 && f <= T + 1);
            if (bus.imem_re && f >= 1 && f <= T) begin
                int i = f - 1;
                int l = i / (N * kt);
                int n = (i / kt) % N;
                int k = i % kt;
                check("imem_addr", bus.imem_addr, l * kt + k);
                check("wmem_addr", bus.wmem_addr, n * kt + k);
                check("wmem_re", bus.wmem_re, 1);
            end
            if (bus.vec_valid && f >= 2 && f <= T + 1) begin
                int k   = (f - 2) % kt;
                int rem = M % 16;
                int msk = (k == kt - 1 && rem != 0) ? (1 << rem) - 1 : 'hFFFF;
                check("vec_first", bus.vec_first, k == 0);
                check("vec_last", bus.vec_last, k == kt - 1);
                check("vec_mask", bus.vec_mask, msk);
                if (k == kt - 1) due.push_back(f + lat);
            end
            bus.psum_valid = due.size() > 0 && due[0] <= f;
            if (bus.psum_valid) void'(due.pop_front());
            #1;
            check("omem_we", bus.omem_we, bus.psum_valid);
            if (bus.psum_valid) begin
                check("omem_addr", bus.omem_addr, nw);
                nw++;
                w_last = f;
            end
            if (bus.done) begin
                done_f = f;
                check("done_frame", f, w_last + 2);
                check("writes", nw, L * N);
                check("busy_at_done", bus.busy, 0);
                check("err_ok", bus.err, 0);
`ifdef GEMM_SEQ_CTRL_PERF_CNT_EN
                check("perf_cycles", perf_cycles, f);
`endif
            end else begin
                check("busy", bus.busy, 1);
            end
        end
        if (done_f < 0) check("done_timeout", 0, 1);
        @(negedge ap_clk);
        bus.psum_valid = 1'b0;
        check("done_pulse", bus.done, 0);
        check("idle_busy", bus.busy, 0);
        repeat (3) @(negedge ap_clk);
`ifdef GEMM_SEQ_CTRL_PERF_CNT_EN
        check("perf_hold", perf_cycles, done_f);
`endif
    endtask

    task automatic run_err(input int L, input int M, input int N);
        @(negedge ap_clk);
        bus.dim_l = L;
        bus.dim_m = M;
        bus.dim_n = N;
        bus.start = 1'b1;
        @(negedge ap_clk);
        bus.start = 1'b0;
        check("chk_busy", bus.busy, 1);
        check("chk_done", bus.done, 0);
        check("chk_re", bus.imem_re, 0);
        @(negedge ap_clk);
        check("err_done", bus.done, 1);
        check("err_flag", bus.err, 1);
        check("err_re", bus.imem_re, 0);
        @(negedge ap_clk);
        check("err_done_end", bus.done, 0);
        check("err_sticky", bus.err, 1);
        check("err_idle_re", bus.imem_re, 0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.dim_l      = '0;
        bus.dim_m      = '0;
        bus.dim_n      = '0;
        bus.psum_valid = 1'b0;
        repeat (2) @(negedge ap_clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_re", bus.imem_re, 0);
        check("rst_vec", bus.vec_valid, 0);
        areset = 1'b0;
        @(negedge ap_clk);
        bus.psum_valid = 1'b1;
        #1 check("idle_psum_ignored", bus.omem_we, 0);
        bus.psum_valid = 1'b0;
        run(2, 16, 2, 2, -1);
        run(1, 20, 1, 1, -1);
        run_err(1, 0, 1);
        run_err(65, 16, 1);
        run(1, 16, 1, 0, -1);
        run(4, 256, 4, 5, 100);
        @(negedge ap_clk);
        bus.dim_l = 4;
        bus.dim_m = 256;
        bus.dim_n = 4;
        bus.start = 1'b1;
        @(negedge ap_clk);
        bus.start = 1'b0;
        repeat (20) @(negedge ap_clk);
        check("pre_rst_re", bus.imem_re, 1);
        areset = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_re", bus.imem_re, 0);
        check("arst_addr", bus.imem_addr, 0);
        check("arst_vec", bus.vec_valid, 0);
        check("arst_mask", bus.vec_mask, 0);
        check("arst_done", bus.done, 0);
        @(negedge ap_clk);
        areset = 1'b0;
        run(2, 16, 2, 3, -1);
        for (int r = 0; r < 6; r++)
            run($urandom_range(1, 4), $urandom_range(1, 48), $urandom_range(1, 4), $urandom_range(0, 6), -1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
